// File: rtl/btb_assoc_pred_if.sv
// Fetch-lookup, execute-update and flush signals of the branch target buffer.
// The predictor is the slave; the fetch/execute side is the master.
interface btb_assoc_pred_if #(
    parameter int TARGET_W = 33
) ();
    logic                lookup_en;
    logic [31:0]         lookup_pc;
    logic                hit;
    logic                pred_taken;
    logic [TARGET_W-1:0] target;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [TARGET_W-1:0] upd_target;
    logic                flush_req;
    logic                flush_busy;

    modport master (
        output lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
        input  hit, pred_taken, target, flush_busy
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush_req,
        output hit, pred_taken, target, flush_busy
    );
endinterface

// File: rtl/btb_assoc_pred.sv
// Set-associative BTB: combinational lookup, 2-bit direction counters,
// true-LRU replacement via per-way ages, and a one-set-per-cycle flush engine.
module btb_assoc_pred #(
    parameter int SETS     = 32,
    parameter int WAYS     = 4,
    parameter int TARGET_W = 33,
    localparam int SET_W   = $clog2(SETS),
    localparam int WAY_W   = $clog2(WAYS),
    localparam int TAG_W   = 30 - SET_W
) (
    input  logic              clk,
    input  logic              rst,
    btb_assoc_pred_if.slave   bus
);
    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [SET_W-1:0]    fcnt_q, fcnt_d;

    logic                valid_q  [SETS][WAYS];
    logic                valid_d  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [TAG_W-1:0]    tag_d    [SETS][WAYS];
    logic [TARGET_W-1:0] target_q [SETS][WAYS];
    logic [TARGET_W-1:0] target_d [SETS][WAYS];
    logic [1:0]          cnt_q    [SETS][WAYS];
    logic [1:0]          cnt_d    [SETS][WAYS];
    logic [WAY_W-1:0]    age_q    [SETS][WAYS];
    logic [WAY_W-1:0]    age_d    [SETS][WAYS];

    logic [SET_W-1:0]    lk_set, up_set;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic                lk_hit, up_hit, inv_found;
    logic [WAY_W-1:0]    lk_way, up_way, victim, max_age;
    logic                busy, upd_write, lk_touch;
    logic [WAY_W-1:0]    wr_way;

    assign lk_set = bus.lookup_pc[SET_W+1:2];
    assign lk_tag = bus.lookup_pc[31:SET_W+2];
    assign up_set = bus.upd_pc[SET_W+1:2];
    assign up_tag = bus.upd_pc[31:SET_W+2];
    assign busy   = (state_q == S_FLUSH);

    // Lowest matching way wins when several ways carry the same tag.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        up_hit = 1'b0;
        up_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!up_hit && valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
    end

    // Victim: first invalid way, else the oldest way in the update set.
    always_comb begin
        inv_found = 1'b0;
        victim    = '0;
        max_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[up_set][w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[up_set][w] >= max_age) begin
                    max_age = age_q[up_set][w];
                    victim  = WAY_W'(w);
                end
            end
        end
    end

    assign upd_write = bus.upd_valid && !busy && !bus.flush_req && (up_hit || bus.upd_taken);
    assign wr_way    = up_hit ? up_way : victim;
    assign lk_touch  = bus.lookup_en && lk_hit && !busy && !(upd_write && up_set == lk_set);

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        age_d    = age_q;

        case (state_q)
            S_IDLE: begin
                if (bus.flush_req) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end
            end
            S_FLUSH: begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[fcnt_q][w] = 1'b0;
                    age_d[fcnt_q][w]   = WAY_W'(w);
                end
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == SET_W'(SETS - 1))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (upd_write) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    if (cnt_q[up_set][wr_way] != 2'b11)
                        cnt_d[up_set][wr_way] = cnt_q[up_set][wr_way] + 2'b01;
                    target_d[up_set][wr_way] = bus.upd_target;
                end else if (cnt_q[up_set][wr_way] != 2'b00) begin
                    cnt_d[up_set][wr_way] = cnt_q[up_set][wr_way] - 2'b01;
                end
            end else begin
                valid_d[up_set][wr_way]  = 1'b1;
                tag_d[up_set][wr_way]    = up_tag;
                target_d[up_set][wr_way] = bus.upd_target;
                cnt_d[up_set][wr_way]    = 2'b10;
            end
            for (int v = 0; v < WAYS; v++)
                if (age_q[up_set][v] < age_q[up_set][wr_way])
                    age_d[up_set][v] = age_q[up_set][v] + 1'b1;
            age_d[up_set][wr_way] = '0;
        end

        if (lk_touch) begin
            for (int v = 0; v < WAYS; v++)
                if (age_q[lk_set][v] < age_q[lk_set][lk_way])
                    age_d[lk_set][v] = age_q[lk_set][v] + 1'b1;
            age_d[lk_set][lk_way] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    cnt_q[s][w]    <= 2'b00;
                    age_q[s][w]    <= WAY_W'(w);
                end
            end
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            age_q    <= age_d;
        end
    end

    assign bus.hit        = lk_hit && !busy;
    assign bus.pred_taken = bus.hit && cnt_q[lk_set][lk_way][1];
    assign bus.target     = bus.hit ? target_q[lk_set][lk_way] : '0;
    assign bus.flush_busy = busy;
endmodule

// File: tb/tb_btb_assoc_pred.sv
// Directed vector bench for btb_assoc_pred: table-driven update/lookup checks
// plus hand-written flush and asynchronous-reset sequences.
module tb_btb_assoc_pred;
    localparam int TW = 33;

    localparam int OP_RST = 0;
    localparam int OP_UPD = 1;
    localparam int OP_LK  = 2;

    typedef struct {
        int          op;
        logic [31:0] pc;
        logic        taken;
        logic [TW-1:0] tgt;
        logic        e_hit;
        logic        e_pt;
        logic [TW-1:0] e_tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vq[$];

    btb_assoc_pred_if #(.TARGET_W(TW)) bus ();

    btb_assoc_pred #(.SETS(32), .WAYS(4), .TARGET_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk_rst();
        vec_t v;
        v = '{OP_RST, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0};
        return v;
    endfunction

    function automatic vec_t mk_upd(input logic [31:0] pc, input logic t, input logic [TW-1:0] tg);
        vec_t v;
        v = '{OP_UPD, pc, t, tg, 1'b0, 1'b0, '0};
        return v;
    endfunction

    function automatic vec_t mk_lk(input logic [31:0] pc, input logic h, input logic pt,
                                   input logic [TW-1:0] tg);
        vec_t v;
        v = '{OP_LK, pc, 1'b0, '0, h, pt, tg};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        case (v.op)
            OP_RST: do_reset();
            OP_UPD: begin
                bus.upd_valid  = 1'b1;
                bus.upd_pc     = v.pc;
                bus.upd_taken  = v.taken;
                bus.upd_target = v.tgt;
                tick();
                bus.upd_valid  = 1'b0;
            end
            default: begin
                bus.lookup_en = 1'b1;
                bus.lookup_pc = v.pc;
                @(negedge clk);
                check($sformatf("hit pc=%h", v.pc), 64'(bus.hit), 64'(v.e_hit));
                check($sformatf("pred_taken pc=%h", v.pc), 64'(bus.pred_taken), 64'(v.e_pt));
                check($sformatf("target pc=%h", v.pc), 64'(bus.target), 64'(v.e_tgt));
                tick();
                bus.lookup_en = 1'b0;
            end
        endcase
    endtask

    initial begin
        int cycles;
        bus.lookup_en  = 1'b0;
        bus.lookup_pc  = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.flush_req  = 1'b0;

        do_reset();
        bus.lookup_pc = 32'h100;
        @(negedge clk);
        check("reset hit", 64'(bus.hit), 64'd0);
        check("reset pred_taken", 64'(bus.pred_taken), 64'd0);
        check("reset target", 64'(bus.target), 64'd0);
        check("reset flush_busy", 64'(bus.flush_busy), 64'd0);
        tick();

        // Allocation and counter behaviour.
        vq.push_back(mk_lk(32'h100, 0, 0, 33'h0));
        vq.push_back(mk_upd(32'h100, 1, 33'h200));
        vq.push_back(mk_lk(32'h100, 1, 1, 33'h200));
        vq.push_back(mk_upd(32'h100, 0, 33'h999));
        vq.push_back(mk_upd(32'h100, 0, 33'h999));
        vq.push_back(mk_lk(32'h100, 1, 0, 33'h200));
        vq.push_back(mk_upd(32'h100, 1, 33'h1_0000_0300));
        vq.push_back(mk_upd(32'h100, 1, 33'h1_0000_0300));
        vq.push_back(mk_upd(32'h100, 1, 33'h1_0000_0300));
        vq.push_back(mk_upd(32'h100, 1, 33'h1_0000_0300));
        vq.push_back(mk_lk(32'h100, 1, 1, 33'h1_0000_0300));
        vq.push_back(mk_upd(32'h100, 0, 33'h0));
        vq.push_back(mk_lk(32'h100, 1, 1, 33'h1_0000_0300));
        vq.push_back(mk_lk(32'h103, 1, 1, 33'h1_0000_0300));
        // LRU victim selection in set 0.
        vq.push_back(mk_rst());
        vq.push_back(mk_upd(32'h000, 1, 33'h10));
        vq.push_back(mk_upd(32'h080, 1, 33'h11));
        vq.push_back(mk_upd(32'h100, 1, 33'h12));
        vq.push_back(mk_upd(32'h180, 1, 33'h13));
        vq.push_back(mk_lk(32'h000, 1, 1, 33'h10));
        vq.push_back(mk_upd(32'h200, 1, 33'h14));
        vq.push_back(mk_lk(32'h080, 0, 0, 33'h0));
        vq.push_back(mk_lk(32'h000, 1, 1, 33'h10));
        vq.push_back(mk_lk(32'h100, 1, 1, 33'h12));
        vq.push_back(mk_lk(32'h180, 1, 1, 33'h13));
        vq.push_back(mk_lk(32'h200, 1, 1, 33'h14));
        // Not-taken miss never allocates.
        vq.push_back(mk_rst());
        vq.push_back(mk_upd(32'h40C, 0, 33'h55));
        vq.push_back(mk_lk(32'h40C, 0, 0, 33'h0));
        // Fill four sets ahead of the flush sequence.
        vq.push_back(mk_rst());
        vq.push_back(mk_upd(32'h000, 1, 33'h20));
        vq.push_back(mk_upd(32'h004, 1, 33'h21));
        vq.push_back(mk_upd(32'h008, 1, 33'h22));
        vq.push_back(mk_upd(32'h00C, 1, 33'h23));
        vq.push_back(mk_lk(32'h004, 1, 1, 33'h21));
        vq.push_back(mk_lk(32'h00C, 1, 1, 33'h23));

        foreach (vq[i]) apply(vq[i]);

        // Flush: busy for 32 cycles, hit held low, mid-flush request and update ignored.
        bus.flush_req = 1'b1;
        bus.lookup_en = 1'b1;
        bus.lookup_pc = 32'h004;
        tick();
        bus.flush_req = 1'b0;
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            if (!bus.flush_busy) break;
            cycles++;
            check($sformatf("hit during flush cycle %0d", cycles), 64'(bus.hit), 64'd0);
            bus.flush_req = (cycles == 3);
            bus.upd_valid = (cycles == 5);
            bus.upd_pc    = 32'h010;
            bus.upd_taken = 1'b1;
            bus.upd_target = 33'h77;
        end
        bus.flush_req = 1'b0;
        bus.upd_valid = 1'b0;
        bus.lookup_en = 1'b0;
        check("flush busy cycles", 64'(cycles), 64'd32);
        tick();

        vq.delete();
        vq.push_back(mk_lk(32'h000, 0, 0, 33'h0));
        vq.push_back(mk_lk(32'h004, 0, 0, 33'h0));
        vq.push_back(mk_lk(32'h008, 0, 0, 33'h0));
        vq.push_back(mk_lk(32'h00C, 0, 0, 33'h0));
        vq.push_back(mk_lk(32'h010, 0, 0, 33'h0));
        vq.push_back(mk_upd(32'h008, 1, 33'h30));
        vq.push_back(mk_lk(32'h008, 1, 1, 33'h30));
        foreach (vq[i]) apply(vq[i]);

        // Asynchronous reset in the middle of a flush.
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        cycles = 0;
        while (cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        #1;
        rst = 1'b1;
        #1;
        check("async rst flush_busy", 64'(bus.flush_busy), 64'd0);
        check("async rst hit", 64'(bus.hit), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk_lk(32'h008, 0, 0, 33'h0));
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        @(negedge clk);
        check("flush accepted after reset", 64'(bus.flush_busy), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btb_assoc_pred.md
Name: btb_assoc_pred

Overview:
Parametrised set-associative branch target buffer with per-entry 2-bit direction counters, true-LRU replacement and a multi-cycle flush engine. It sits in the fetch stage. Fetch gets a combinational lookup of hit, target and predicted direction. Execute feeds back resolved branches on the update port. The redirect/fence logic issues flushes.

Parameters:
SETS, 32, number of sets; power of two, at least 2
WAYS, 4, ways per set; power of two, at least 2
TARGET_W, 33, width of the stored target payload
SET_W, $clog2(SETS), set index width (derived)
WAY_W, $clog2(WAYS), way index / LRU age width (derived)
TAG_W, 30-SET_W, tag width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lookup_en  in  1  fetch lookup valid; gates LRU touch only
lookup_pc  in  32  PC to predict
hit  out  1  valid tag match in lookup set (combinational)
pred_taken  out  1  MSB of hit entry counter; 0 on miss
target  out  TARGET_W  hit entry target; 0 on miss
upd_valid  in  1  resolved branch update
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  resolved direction
upd_target  in  TARGET_W  resolved target
flush_req  in  1  start invalidation of all entries
flush_busy  out  1  flush in progress

Behaviour:
- Index and tag: set = pc[SET_W+1:2], tag = pc[31:SET_W+2]; pc[1:0] ignored.
- Per entry: valid, tag, target, 2-bit counter cnt, WAY_W-bit age.
- Lookup is purely combinational with no write bypass. An update in cycle N becomes visible in cycle N+1.
- Multiple matching ways select the lowest index. hit, pred_taken and target are 0 while flush_busy=1.
- Ages form a permutation of 0..WAYS-1 per set; the largest age is least recently used.
- Touching way w: ways with age < age[w] increment, and age[w] becomes 0.
- A touch occurs on lookup_en&hit at the lookup set, or on any update write at the update set.
- If both touch the same set in one cycle, only the update touch applies.
- Update when upd_valid=1 and not flushing, with existing matching way:
  - cnt saturating +1 if taken, saturating -1 if not taken; saturates at 2'b11 and 2'b00.
  - target is overwritten only if taken.
  - The way is touched.
- Update on a miss with upd_taken=1: allocate the victim way.
  - Victim is the lowest-index invalid way, otherwise the way with the largest age.
  - Sets valid=1, tag, target, cnt=2'b10; the way is touched.
- Update on a miss with upd_taken=0: no state change.
- FSM states IDLE and FLUSH.
  - IDLE to FLUSH on flush_req; the counter starts at 0.
  - In FLUSH, each cycle clears valid for all ways of set[counter] and resets ages to the way index; the counter increments.
  - After set SETS-1 is cleared, return to IDLE. flush_busy=1 for exactly SETS cycles starting the cycle after flush_req.
  - flush_req while in FLUSH is ignored. Update and lookup touches are ignored while in FLUSH.
  - flush_req and upd_valid in the same IDLE cycle: the update is dropped.
- Reset (asynchronous, any time including mid-flush):
  - FSM goes to IDLE, flush_busy=0, counter=0.
  - All valid=0, cnt=0, age[w]=w; targets and tags are 0.
  - Outputs hit=0, pred_taken=0, target=0.
- Latency: prediction has 0 cycles; update takes 1 cycle; flush takes SETS cycles.

Test Plan:
- Reset, then lookup 0x100 gives hit=0. Update pc=0x100 taken target=0x200, then next-cycle lookup 0x100 gives hit=1, target=0x200, pred_taken=1.
- Counters: from the previous case, two not-taken updates give hit=1, pred_taken=0 and target still 0x200. Four taken updates give pred_taken=1 with cnt saturated at 11. One not-taken update then gives pred_taken=1.
- LRU victim: allocate taken 0x000, 0x080, 0x100, 0x180 into set 0 (ways 0-3). Touch-lookup 0x000, then allocate 0x200. Lookups then give 0x080 miss, and 0x000, 0x100, 0x180, 0x200 hit.
- No-alloc: a not-taken update of 0x40C on an empty BTB leaves the next lookup of 0x40C at hit=0.
- Flush: fill 4 sets, then pulse flush_req. flush_busy is high for exactly 32 cycles and hit=0 throughout. An update at busy cycle 5 is ignored. All lookups miss afterwards, and a new allocation lands in way 0.
- Asynchronous rst asserted at flush cycle 10, between clock edges: flush_busy=0 and hit=0 immediately. After release, the BTB is empty and flush_req is accepted again.
